// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: NUM_BITS operand width, FSM state encoding, divide-by-zero quotient.
package div_pkg;

   localparam int NUM_BITS = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Quotient reported when the divisor is zero: all ones.
   localparam logic [NUM_BITS-1:0] ZERO_DIV_QUOTIENT = '1;

endpackage

// File: rtl/sub_stage_17bit.sv
// Combinational WIDTH-bit subtract a - b, built as a + ~b + 1 like the ripple adder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports: a, b (WIDTH) operands; diff (WIDTH) = a - b mod 2^WIDTH;
//        borrow = 1 when a < b (inverted carry out of the add).
module sub_stage_17bit
   import div_pkg::*;
#(
   parameter int WIDTH = NUM_BITS + 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   // One extra bit so the carry out of a + ~b + 1 is visible.
   logic [WIDTH:0] sum;

   assign sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign diff   = sum[WIDTH-1:0];
   // Carry out set means no borrow was needed.
   assign borrow = ~sum[WIDTH];

endmodule

// File: rtl/sequential_divider_16bit.sv
// Unsigned restoring divider, one shift-subtract step per clock.
// Latency: NUM_BITS+1 clocks from accepted start to done (1 clock on divide-by-zero).
// Backpressure: start is only sampled in IDLE; requests in CALC/DONE are dropped.
//
// Ports: clk, n_rst (async active-low); start, dividend, divisor in;
//        busy (in CALC), done (1-cycle pulse), quotient, remainder, div_by_zero out.
module sequential_divider_16bit #(
   parameter int NUM_BITS = div_pkg::NUM_BITS
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [NUM_BITS-1:0] dividend,
   input  logic [NUM_BITS-1:0] divisor,
   output logic                busy,
   output logic                done,
   output logic [NUM_BITS-1:0] quotient,
   output logic [NUM_BITS-1:0] remainder,
   output logic                div_by_zero
);

   import div_pkg::*;

   localparam int CNT_W = $clog2(NUM_BITS);

   state_t              state;
   logic [CNT_W-1:0]    iter_cnt;
   // q_work starts as the dividend and is shifted out MSB-first into the
   // partial remainder while quotient bits are shifted in at the bottom.
   logic [NUM_BITS-1:0] q_work;
   logic [NUM_BITS-1:0] r_work;
   logic [NUM_BITS-1:0] d_work;

   logic [NUM_BITS:0]   r17;
   logic [NUM_BITS:0]   d17;
   logic [NUM_BITS:0]   t17;
   logic                t_borrow;
   logic                t_msb_unused;
   logic [NUM_BITS-1:0] q_next;
   logic [NUM_BITS-1:0] r_next;

   // 17-bit partial remainder keeps the shifted-out bit so nothing is truncated.
   assign r17 = {r_work, q_work[NUM_BITS-1]};
   assign d17 = {1'b0, d_work};

   sub_stage_17bit #(
      .WIDTH (NUM_BITS + 1)
   ) u_sub (
      .a      (r17),
      .b      (d17),
      .diff   (t17),
      .borrow (t_borrow)
   );

   // When the subtract succeeds, r17 < 2*d so the difference always fits in
   // NUM_BITS bits; its top bit is always zero.
   assign t_msb_unused = t17[NUM_BITS];

   always_comb begin
      q_next = {q_work[NUM_BITS-2:0], ~t_borrow};
      r_next = t_borrow ? r17[NUM_BITS-1:0] : t17[NUM_BITS-1:0];
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         iter_cnt    <= '0;
         q_work      <= '0;
         r_work      <= '0;
         d_work      <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  iter_cnt <= '0;
                  r_work   <= '0;
                  q_work   <= dividend;
                  d_work   <= divisor;
                  if (divisor == '0) begin
                     // Skip iteration entirely; results are defined constants.
                     quotient    <= ZERO_DIV_QUOTIENT;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               q_work   <= q_next;
               r_work   <= r_next;
               iter_cnt <= iter_cnt + 1'b1;
               if (iter_cnt == CNT_W'(NUM_BITS - 1)) begin
                  quotient    <= q_next;
                  remainder   <= r_next;
                  div_by_zero <= 1'b0;
                  iter_cnt    <= '0;
                  state       <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state == CALC);
   assign done = (state == DONE);

endmodule

// File: tb/tb_sequential_divider_16bit.sv
module tb_sequential_divider_16bit;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int n_checks = 0;
   int n_err = 0;

   sequential_divider_16bit #(.NUM_BITS(16)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: plain / and %, plus a count of edges until the result lands.
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [15:0] m_q = '0;
   logic [15:0] m_r = '0;
   logic        m_z = 1'b0;
   logic [15:0] p_q = '0;
   logic [15:0] p_r = '0;
   int          m_left = 0;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
         m_z    <= 1'b0;
         m_left <= 0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left != 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_q    <= p_q;
            m_r    <= p_r;
            m_z    <= 1'b0;
         end
      end else if (start) begin
         if (divisor == 16'd0) begin
            m_q    <= 16'hFFFF;
            m_r    <= dividend;
            m_z    <= 1'b1;
            m_done <= 1'b1;
         end else begin
            p_q    <= dividend / divisor;
            p_r    <= dividend % divisor;
            m_left <= 16;
            m_busy <= 1'b1;
         end
      end
   end

   // Cycle-by-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_done", {31'd0, done}, {31'd0, m_done});
      chk("cyc_quotient", {16'd0, quotient}, {16'd0, m_q});
      chk("cyc_remainder", {16'd0, remainder}, {16'd0, m_r});
      chk("cyc_div_by_zero", {31'd0, div_by_zero}, {31'd0, m_z});
   end

   // Issue one op; lat = 1 means done was seen right after the accepting edge.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int bsy);
      @(posedge clk); #1;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 1;
      bsy   = 0;
      while (!done && lat < 40) begin
         if (busy) bsy++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic chk_res(input string nm, input logic [15:0] q, input logic [15:0] r,
                          input logic z);
      chk({nm, "_q"}, {16'd0, quotient}, {16'd0, q});
      chk({nm, "_r"}, {16'd0, remainder}, {16'd0, r});
      chk({nm, "_z"}, {31'd0, div_by_zero}, {31'd0, z});
   endtask

   initial begin
      int lat;
      int bsy;
      int nd;
      int first;
      int second;
      logic [15:0] a;
      logic [15:0] b;

      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk_res("rst", 16'd0, 16'd0, 1'b0);
      n_rst = 1'b1;

      // 1: basic op, latency and busy width
      run_op(16'd1000, 16'd7, lat, bsy);
      chk("t1_latency", lat, 17);
      chk("t1_busy_cycles", bsy, 16);
      chk_res("t1", 16'd142, 16'd6, 1'b0);

      // 2: extremes
      run_op(16'hFFFF, 16'd1, lat, bsy);
      chk_res("t2a", 16'hFFFF, 16'd0, 1'b0);
      run_op(16'hFFFF, 16'hFFFF, lat, bsy);
      chk_res("t2b", 16'd1, 16'd0, 1'b0);

      // 3: dividend smaller than divisor, zero dividend
      run_op(16'd5, 16'd10, lat, bsy);
      chk_res("t3a", 16'd0, 16'd5, 1'b0);
      run_op(16'd0, 16'd3, lat, bsy);
      chk_res("t3b", 16'd0, 16'd0, 1'b0);

      // 4: divide by zero, then a valid op clears the flag
      run_op(16'h1234, 16'd0, lat, bsy);
      chk("t4_latency", lat, 1);
      chk("t4_busy_cycles", bsy, 0);
      chk_res("t4a", 16'hFFFF, 16'h1234, 1'b1);
      run_op(16'd100, 16'd9, lat, bsy);
      chk_res("t4b", 16'd11, 16'd1, 1'b0);

      // 5: start and operand changes during CALC are ignored
      @(posedge clk); #1;
      dividend = 16'd1000; divisor = 16'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      dividend = 16'd50; divisor = 16'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; dividend = 16'h5555; divisor = 16'd3;
      nd = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      chk("t5_done_count", nd, 1);
      chk_res("t5", 16'd142, 16'd6, 1'b0);

      // 6: asynchronous reset mid-CALC discards the op
      @(posedge clk); #1;
      dividend = 16'd1000; divisor = 16'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      n_rst = 1'b0;
      #1;
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_done", {31'd0, done}, 32'd0);
      chk_res("t6_rst", 16'd0, 16'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
      nd = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      chk("t6_no_done", nd, 0);
      run_op(16'd40000, 16'd300, lat, bsy);
      chk("t6_latency", lat, 17);
      chk_res("t6", 16'd133, 16'd100, 1'b0);

      // 7: start held high is accepted once per IDLE visit
      @(posedge clk); #1;
      dividend = 16'd100; divisor = 16'd9; start = 1'b1;
      first = -1;
      second = -1;
      for (int i = 0; i < 60 && second < 0; i++) begin
         @(posedge clk); #1;
         if (done) begin
            if (first < 0) first = i;
            else second = i;
         end
      end
      start = 1'b0;
      chk("t7_done_spacing", second - first, 18);
      chk_res("t7", 16'd11, 16'd1, 1'b0);
      repeat (3) @(posedge clk);

      // Random sweep: invariant and latency
      for (int i = 0; i < 500; i++) begin
         a = 16'($urandom);
         if (i % 4 == 0) b = 16'($urandom_range(1, 15));
         else if (i % 50 == 7) b = 16'd0;
         else b = 16'($urandom);
         run_op(a, b, lat, bsy);
         if (b == 16'd0) begin
            chk("rnd_lat_dbz", lat, 1);
            chk_res("rnd_dbz", 16'hFFFF, a, 1'b0 | 1'b1);
         end else begin
            chk("rnd_lat", lat, 17);
            chk("rnd_invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk("rnd_rem_lt_div", {31'd0, remainder < b}, 32'd1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
